// File: rtl/alu_issue_8bit.sv
// alu_issue_8bit: command FIFO feeding an IDLE/EXEC/HOLD issue FSM that drives an external 8-bit ALU.
// Define ALU_ISSUE_STATS_EN to add saturating op_count/zero_count result statistics.
module alu_issue_8bit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_opcode,
  input  logic [7:0] alu_y,
  input  logic       alu_carryout,
  input  logic       alu_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic       res_carry,
  output logic       res_zero,
  output logic [1:0] res_opcode,
  output logic [4:0] fifo_count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] zero_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;
  state_t r_state, w_next;
  logic [17:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0] r_count;
  logic [7:0] r_alu_a, r_alu_b, r_res_y;
  logic [1:0] r_alu_op, r_res_op;
  logic r_res_valid, r_res_carry, r_res_zero;
  logic w_nempty, w_push, w_pop, w_capture, w_release;
  logic [17:0] w_head;
  assign cmd_ready  = r_count != 5'(FIFO_DEPTH);
  assign w_nempty   = r_count != 5'd0;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_y      = r_res_y;
  assign res_carry  = r_res_carry;
  assign res_zero   = r_res_zero;
  assign res_opcode = r_res_op;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
  // Pop decisions use the registered count, so a same-edge push is never popped early.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + 5'(w_push) - 5'(w_pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == S_IDLE) ? (w_nempty ? S_EXEC : S_IDLE) :
             (r_state == S_EXEC) ? S_HOLD :
             (r_state == S_HOLD) ? (res_ready ? (w_nempty ? S_EXEC : S_IDLE) : S_HOLD) : S_IDLE;
  always_comb begin
    w_pop     = w_nempty && (r_state == S_IDLE || (r_state == S_HOLD && res_ready));
    w_capture = r_state == S_EXEC;
    w_release = r_state == S_HOLD && res_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r_alu_op, r_alu_a, r_alu_b} <= '0;
      {r_res_op, r_res_carry, r_res_zero, r_res_y} <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) {r_alu_op, r_alu_a, r_alu_b} <= w_head;
      if (w_capture) {r_res_op, r_res_carry, r_res_zero, r_res_y} <= {r_alu_op, alu_carryout, alu_zero, alu_y};
      r_res_valid <= w_capture | (r_res_valid & ~w_release);
    end
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_op_cnt, r_zero_cnt;
  logic w_hs;
  assign w_hs       = r_res_valid && res_ready;
  assign op_count   = r_op_cnt;
  assign zero_count = r_zero_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op_cnt   <= '0;
      r_zero_cnt <= '0;
    end else begin
      if (w_hs && r_op_cnt != 16'hFFFF) r_op_cnt <= r_op_cnt + 16'd1;
      if (w_hs && r_res_zero && r_zero_cnt != 16'hFFFF) r_zero_cnt <= r_zero_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_issue_8bit.sv
// tb_alu_issue_8bit: directed and randomized checks of alu_issue_8bit against a queue-based reference model.
module tb_alu_issue_8bit;
  logic clk, rst_n, cmd_valid, cmd_ready, res_valid, res_ready;
  logic [1:0] cmd_opcode, alu_opcode, res_opcode;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
  logic alu_carryout, alu_zero, res_carry, res_zero;
  logic [4:0] fifo_count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count, zero_count;
`endif
  int n_cmp = 0, n_err = 0, cyc = 0;
  bit rnd = 0;
  logic [11:0] exp_q[$];
  int hs_t[$];

  alu_issue_8bit #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_carry(res_carry), .res_zero(res_zero), .res_opcode(res_opcode),
    .fifo_count(fifo_count)
`ifdef ALU_ISSUE_STATS_EN
    , .op_count(op_count), .zero_count(zero_count)
`endif
  );

  // Arithmetic meaning of each opcode: {carry/borrow, zero, y}
  function automatic logic [9:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = (op == 2'd0) ? {1'b0, a} + {1'b0, b} :
        (op == 2'd1) ? {1'b0, a} - {1'b0, b} :
        (op == 2'd2) ? {1'b0, a & b} : {1'b0, a | b};
    return {r[8], r[7:0] == 8'd0, r[7:0]};
  endfunction

  assign {alu_carryout, alu_zero, alu_y} = ref_alu(alu_opcode, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [12:0] prev;
  bit prev_hold = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_hold = 0;
    else begin
      if (prev_hold) chk("hold_stable", {3'd0, res_valid, res_opcode, res_carry, res_zero, res_y}, {3'd0, prev});
      prev_hold = res_valid && !res_ready;
      prev = {res_valid, res_opcode, res_carry, res_zero, res_y};
      if (res_valid && res_ready) begin
        hs_t.push_back(cyc);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_result: got y=%h with no command outstanding", res_y);
        end
        if (exp_q.size() != 0) chk("result", {4'd0, res_opcode, res_carry, res_zero, res_y}, {4'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("accept", {15'd0, ok}, 16'd1);
    if (ok) exp_q.push_back({op, ref_alu(op, a, b)});
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    chk("drain", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    #12;
    chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_fifo_count", {11'd0, fifo_count}, 16'd0);
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_alu", {alu_opcode, alu_a}, 10'd0);
    chk("rst_alu_b", {8'd0, alu_b}, 16'd0);
    chk("rst_res", {5'd0, res_opcode, res_carry, res_zero, res_y}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // single ADD: latency check around the accept edge
    res_ready = 1'b1;
    send(2'd0, 8'd10, 8'd20);
    chk("lat_count_T", {11'd0, fifo_count}, 16'd1);
    chk("lat_alu_T", {8'd0, alu_a}, 16'd0);
    tick();
    chk("lat_alu_a_T1", {8'd0, alu_a}, 16'd10);
    chk("lat_alu_b_T1", {8'd0, alu_b}, 16'd20);
    chk("lat_valid_T1", {15'd0, res_valid}, 16'd0);
    tick();
    chk("lat_valid_T2", {15'd0, res_valid}, 16'd1);
    chk("lat_res_T2", {5'd0, res_opcode, res_carry, res_zero, res_y}, {5'd0, 2'd0, 1'b0, 1'b0, 8'd30});
    drain();
    send(2'd0, 8'd200, 8'd100);
    send(2'd1, 8'd20, 8'd20);
    drain();
`ifdef ALU_ISSUE_STATS_EN
    chk("op_count", op_count, 16'd3);
    chk("zero_count", zero_count, 16'd1);
`endif
    send(2'd2, 8'hCC, 8'hAA);
    send(2'd3, 8'hCC, 8'hAA);
    drain();
    // backpressure: fill result register plus FIFO, sixth command must wait
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'(i), 8'(i * 37 + 5), 8'(i * 11 + 3));
    chk("bp_count", {11'd0, fifo_count}, 16'd4);
    chk("bp_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("bp_res_valid", {15'd0, res_valid}, 16'd1);
    cmd_valid = 1'b1; cmd_opcode = 2'd1; cmd_a = 8'd7; cmd_b = 8'd9;
    repeat (3) tick();
    chk("bp_still_full", {11'd0, fifo_count}, 16'd4);
    hs_t.delete();
    res_ready = 1'b1;
    send(2'd1, 8'd7, 8'd9);
    drain();
    chk("bp_results", 16'(hs_t.size()), 16'd6);
    for (int i = 1; i < hs_t.size(); i++) chk("bp_gap", 16'(hs_t[i] - hs_t[i-1]), 16'd2);
    // random traffic with random result backpressure
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(2'($urandom), 8'($urandom), 8'($urandom));
    end
    rnd = 0;
    res_ready = 1'b1;
    drain();
    // asynchronous reset while holding a result with three commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd0, 8'(i + 1), 8'd1);
    chk("mr_count", {11'd0, fifo_count}, 16'd3);
    chk("mr_valid", {15'd0, res_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mr_async_valid", {15'd0, res_valid}, 16'd0);
    chk("mr_async_count", {11'd0, fifo_count}, 16'd0);
    chk("mr_async_regs", {alu_a, res_y}, 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (10) tick();
    chk("mr_after_valid", {15'd0, res_valid}, 16'd0);
    chk("mr_after_count", {11'd0, fifo_count}, 16'd0);
    send(2'd0, 8'd1, 8'd2);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_8bit.md
ALU_ISSUE_8BIT -- requirements
Module: alu_issue_8bit

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries; SHALL be a power of two in 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Ports: cmd_valid input 1, cmd_ready output 1, cmd_opcode input 2 (00 ADD, 01 SUB, 10 AND, 11 OR), cmd_a input 8, cmd_b input 8  command handshake.
REQ-005 Ports: alu_a output 8, alu_b output 8, alu_opcode output 2  registered drive to the downstream 8-bit ALU.
REQ-006 Ports: alu_y input 8, alu_carryout input 1, alu_zero input 1  combinational ALU result returning.
REQ-007 Ports: res_valid output 1, res_ready input 1, res_y output 8, res_carry output 1, res_zero output 1, res_opcode output 2  result handshake.
REQ-008 Port: fifo_count output 5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-010 Command transfer SHALL occur on an edge where cmd_valid && cmd_ready; cmd_ready SHALL equal (fifo_count != FIFO_DEPTH) from registered state.
REQ-011 FIFO SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-012 FSM states SHALL be IDLE, EXEC, HOLD.
REQ-013 IDLE: if fifo_count != 0, pop head into alu_a/alu_b/alu_opcode and go EXEC; else stay.
REQ-014 EXEC: capture alu_y, alu_carryout, alu_zero and the issued opcode into res_* registers, set res_valid, go HOLD; exactly one cycle.
REQ-015 HOLD: res_* and res_valid SHALL stay stable while res_ready low; on res_ready high, clear res_valid and go IDLE, unless FIFO non-empty, in which case pop next entry into alu_* and go EXEC on the same edge.
REQ-016 Latency: command accepted at edge T into empty FIFO with FSM IDLE -> alu_* updated at T+1 -> res_valid high after T+2; sustained throughput one result per 2 cycles.
REQ-017 alu_* SHALL hold the last issued values when not in EXEC.
REQ-018 Results SHALL be passed unmodified from ALU outputs; no arithmetic in this block.
REQ-019 A command pushed into an empty FIFO on the same edge the FSM checks IDLE SHALL NOT be popped until the following edge.

Reset
REQ-020 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, fifo_count 0, cmd_ready 1 after release, res_valid 0, res_y/res_carry/res_zero/res_opcode 0, alu_a/alu_b/alu_opcode 0.
REQ-021 Reset mid-operation SHALL discard all queued and in-flight commands; no result emitted for them.

Configuration
REQ-030 Macro ALU_ISSUE_STATS_EN defined: add outputs op_count output 16 and zero_count output 16; op_count increments on each result handshake, zero_count on each handshake with res_zero 1; both saturate at 16'hFFFF; reset to 0.
REQ-031 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-040 ADD a=10 b=20, res_ready=1 -> two cycles after accept: res_y=30, res_carry=0, res_zero=0, res_opcode=00.
REQ-041 ADD a=200 b=100 -> res_y=44, res_carry=1; SUB a=20 b=20 -> res_y=0, res_zero=1.
REQ-042 res_ready=0, push 6 commands back-to-back -> 1 in result register, 4 in FIFO, cmd_ready low at fifo_count=4, 6th waits; raise res_ready -> results emerge in push order, one every 2 cycles.
REQ-043 AND 8'hCC,8'hAA then OR 8'hCC,8'hAA -> res_y 8'h88 then 8'hEE, order preserved.
REQ-044 Assert rst_n low while in HOLD with 3 queued -> res_valid 0, fifo_count 0 asynchronously; no stale result after release.
REQ-045 With ALU_ISSUE_STATS_EN: run REQ-040/041 sequence -> op_count=3, zero_count=1.
